coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- N-CPU successor to the 2-CPU memory controller: arbitrates instruction fetches, dirty writebacks and coherent data misses from CPUS L1 cache pairs onto one RAM port.
- Runs MSI snooping with cache-to-cache forwarding; blocks are BLOCK_WORDS words long.
- Sits between the per-CPU caches (cache_control_if, cc modport) and the RAM model.

Parameters:
- CPUS, 2, number of CPU/cache pairs, ≥2.
- BLOCK_WORDS, 2, words per cache block, power of two ≥1.
- CPUID_W, $clog2(CPUS), width of the grant index.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ccif  cc modport  -  cache_control_if, vectors widened to CPUS. Per CPU: iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload, ccwrite/cctrans/ccwait/ccinv/ccsnoopaddr. Shared RAM signals: ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate.

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, word_cnt=0.
- Reset values of all outputs: iwait/dwait all 1, all loads 0, ramREN/ramWEN 0, ramaddr/ramstore 0, ccwait/ccinv 0, ccsnoopaddr 0.
- nRST mid-transfer: the state machine aborts to IDLE immediately. No partial-block recovery.
- States: IDLE, WB, SNOOP, C2C, LOAD, IFETCH.
- IDLE request classes, fixed priority: (1) any dWEN → WB; (2) any dREN → SNOOP; (3) any iREN → IFETCH.
- Within a class, round-robin picks the first requester at or after rr_ptr (mod CPUS). The winner is latched into grant on the IDLE exit edge.
- WB:
  - ramWEN=1, ramaddr=daddr[grant], ramstore=dstore[grant].
  - On ramstate==ACCESS: dwait[grant]=0 for that cycle and word_cnt++.
  - After BLOCK_WORDS accesses → IDLE, rr_ptr=grant+1 (wraps at CPUS).
- SNOOP (exactly 1 cycle):
  - ccwait[grant]=1; ccwait[j]=1 and ccsnoopaddr[j]=daddr[grant] for every j≠grant.
  - Responder = lowest j≠grant with cctrans[j]=1 this cycle. If one exists → C2C, responder latched; otherwise → LOAD.
- C2C:
  - Holds ccwait/ccsnoopaddr as in SNOOP; dload[grant]=dstore[resp].
  - ccinv[j]=ccwrite[grant] for all j≠grant.
  - ramWEN=1, ramaddr=daddr[resp], ramstore=dstore[resp].
  - On ACCESS: dwait[grant]=0, dwait[resp]=0, word_cnt++. After BLOCK_WORDS → IDLE, rr_ptr=grant+1.
- LOAD:
  - ccwait held on all other CPUs; ccinv[j]=ccwrite[grant] for all j≠grant.
  - ramREN=1, ramaddr=daddr[grant], dload[grant]=ramload.
  - On ACCESS: dwait[grant]=0, word_cnt++. After BLOCK_WORDS → IDLE.
- IFETCH:
  - ramREN=1, ramaddr=iaddr[grant], iload[grant]=ramload.
  - On ACCESS: iwait[grant]=0, then → IDLE, rr_ptr=grant+1.
- Requester withdrawal: if the granted CPU drops its request mid-transaction, go to IDLE without advancing rr_ptr.
- ramstate: BUSY/FREE hold the state. ERROR is treated as BUSY, i.e. the access retries.
- Latency: with zero-wait RAM, a coherent miss takes 1 IDLE + 1 SNOOP + BLOCK_WORDS cycles.
- Simultaneous dWEN and dREN from different CPUs: WB always wins.
- Fairness: every completed transaction moves rr_ptr past its grant, so no requester starves inside its class.
- word_cnt resets to 0 on every IDLE entry.

Optional Feature:
- Macro: COHERENCE_STATS_EN.
- When defined:
  - Adds outputs c2c_cnt[31:0] and memload_cnt[31:0].
  - Each increments by 1 on completion of a C2C or LOAD block respectively. Both saturate at all-ones; reset to 0.
- When undefined: no ports, no counter logic; behaviour otherwise identical.

Decomposition:
- Package coherence_pkg:
  - busstate_t enum {IDLE, WB, SNOOP, C2C, LOAD, IFETCH}.
  - Function rr_pick(req vector, ptr) returning an index and a valid flag.
- Reuse word_t and ramstate_t from cpu_types_pkg.
- Sub-module rr_arbiter: CPUS-wide request, ptr input, grant index/valid outputs. Instantiated once per request class.

Test Plan:
- CPUS=4, BLOCK_WORDS=2, all four iREN high, zero-wait RAM → fetch grants in order 0,1,2,3,0; each iwait low for exactly 1 cycle.
- CPU2 dREN daddr=0x100 with no cctrans response → SNOOP then LOAD: 2 ramREN accesses, dload[2]=RAM words, ccsnoopaddr[0,1,3]=0x100 during SNOOP.
- CPU1 dREN+ccwrite at 0x200, CPU3 cctrans=1 with dstore=0xDEADBEEF → C2C: dload[1]=0xDEADBEEF, ccinv[3]=1, RAM written at 0x200, dwait[1] and dwait[3] both low on ACCESS.
- Same cycle: CPU0 dWEN and CPU1 dREN → WB for CPU0 completes (2 words) before CPU1 enters SNOOP.
- RAM with 3-cycle BUSY plus one ERROR cycle during LOAD → outputs held, no dwait pulse until ACCESS.
- nRST asserted mid-C2C → next cycle all outputs at reset values; with COHERENCE_STATS_EN defined, c2c_cnt=0.

Source files
------------

// File: rtl/coherence_pkg.sv
// Types and the round-robin helper for the coherent bus controller.
//   busstate_t : bus FSM state encoding
//   rr_pick()  : first set bit of req at or after ptr, wrapping modulo n
package coherence_pkg;

  // Upper bound on CPUS supported by rr_pick (the width of its request argument).
  localparam int MAX_CPUS = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    SNOOP  = 3'd2,
    C2C    = 3'd3,
    LOAD   = 3'd4,
    IFETCH = 3'd5
  } busstate_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_CPUS-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_CPUS; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !r.valid && req[j[4:0]]) begin
        r.valid = 1'b1;
        r.idx   = j[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word_t is the data/address word and ramstate_t is the
// handshake state returned by the RAM model.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/cache_control_if.sv
// Cache-to-controller interface, widened to CPUS cache pairs.
//   Per CPU : iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload,
//             ccwrite/cctrans/ccwait/ccinv/ccsnoopaddr
//   Shared  : ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate
//   cc modport is the controller's view.
interface cache_control_if
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) ();

  logic  [CPUS-1:0]        iREN, iwait;
  word_t [CPUS-1:0]        iaddr, iload;
  logic  [CPUS-1:0]        dREN, dWEN, dwait;
  word_t [CPUS-1:0]        daddr, dstore, dload;
  logic  [CPUS-1:0]        ccwrite, cctrans, ccwait, ccinv;
  word_t [CPUS-1:0]        ccsnoopaddr;
  logic                    ramREN, ramWEN;
  word_t                   ramaddr, ramstore, ramload;
  ramstate_t               ramstate;

  modport cc (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans,
           ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one request class.
//   req   : CPUS-wide request vector
//   ptr   : round-robin pointer (search starts here)
//   grant : index of the winning requester
//   valid : at least one request present
module rr_arbiter
  import coherence_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int CPUID_W = $clog2(CPUS)
) (
  input  logic [CPUS-1:0]    req,
  input  logic [CPUID_W-1:0] ptr,
  output logic [CPUID_W-1:0] grant,
  output logic               valid
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_CPUS'(req), 32'(ptr), 32'(CPUS));
    grant = CPUID_W'(pick.idx);
    valid = pick.valid;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// N-CPU coherent bus controller: arbitrates writebacks, coherent data misses
// (MSI snoop with cache-to-cache forwarding) and instruction fetches from CPUS
// L1 cache pairs onto a single RAM port.
//   CLK, nRST : clock, asynchronous active-low reset
//   ccif      : cache_control_if.cc (per-CPU cache signals plus RAM port)
//   c2c_cnt, memload_cnt : block completion counters, present only when
//                          COHERENCE_STATS_EN is defined
//
// state  | meaning
// IDLE   | pick next request: dWEN > dREN > iREN, round-robin within class
// WB     | write dirty block of grant to RAM
// SNOOP  | one cycle: broadcast daddr[grant], look for a cctrans responder
// C2C    | forward responder data to grant, write it back to RAM
// LOAD   | no responder: fill grant's block from RAM
// IFETCH | single-word instruction fetch for grant
module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import coherence_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2,
  parameter int CPUID_W     = $clog2(CPUS)
) (
  input  logic               CLK,
  input  logic               nRST,
  cache_control_if.cc        ccif
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]        c2c_cnt,
  output logic [31:0]        memload_cnt
`endif
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  busstate_t           state, state_nxt;
  logic [CPUID_W-1:0]  grant, grant_nxt, resp, resp_nxt, rr_ptr;
  logic [CNT_W-1:0]    word_cnt, cnt_nxt;
  logic [CPUID_W-1:0]  wb_idx, rd_idx, if_idx, hit_idx;
  logic                wb_valid, rd_valid, if_valid, hit;
  logic                access, word_step, finish;

  rr_arbiter #(.CPUS(CPUS), .CPUID_W(CPUID_W)) u_arb_wb (
    .req(ccif.dWEN), .ptr(rr_ptr), .grant(wb_idx), .valid(wb_valid));
  rr_arbiter #(.CPUS(CPUS), .CPUID_W(CPUID_W)) u_arb_rd (
    .req(ccif.dREN), .ptr(rr_ptr), .grant(rd_idx), .valid(rd_valid));
  rr_arbiter #(.CPUS(CPUS), .CPUID_W(CPUID_W)) u_arb_if (
    .req(ccif.iREN), .ptr(rr_ptr), .grant(if_idx), .valid(if_valid));

  // ERROR is deliberately not ACCESS, so the same word is simply retried.
  assign access = (ccif.ramstate == ACCESS);

  // Lowest-numbered snooper other than the requester supplies the block.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (CPUID_W'(j) != grant && ccif.cctrans[j]) begin
        hit     = 1'b1;
        hit_idx = CPUID_W'(j);
      end
    end
  end

  always_comb begin
    ccif.iwait       = '1;
    ccif.dwait       = '1;
    ccif.iload       = '0;
    ccif.dload       = '0;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;
    state_nxt        = state;
    grant_nxt        = grant;
    resp_nxt         = resp;
    cnt_nxt          = word_cnt;
    word_step        = 1'b0;
    finish           = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (wb_valid) begin
          state_nxt = WB;
          grant_nxt = wb_idx;
        end else if (rd_valid) begin
          state_nxt = SNOOP;
          grant_nxt = rd_idx;
        end else if (if_valid) begin
          state_nxt = IFETCH;
          grant_nxt = if_idx;
        end
      end
      WB: begin
        if (!ccif.dWEN[grant]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          ccif.ramWEN   = 1'b1;
          ccif.ramaddr  = ccif.daddr[grant];
          ccif.ramstore = ccif.dstore[grant];
          if (access) begin
            ccif.dwait[grant] = 1'b0;
            word_step         = 1'b1;
          end
        end
      end
      SNOOP, C2C, LOAD: begin
        if (!ccif.dREN[grant]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          for (int j = 0; j < CPUS; j++) begin
            if (CPUID_W'(j) != grant) begin
              ccif.ccwait[j]      = 1'b1;
              ccif.ccsnoopaddr[j] = ccif.daddr[grant];
              if (state != SNOOP) ccif.ccinv[j] = ccif.ccwrite[grant];
            end
          end
          if (state == SNOOP) begin
            ccif.ccwait[grant] = 1'b1;
            if (hit) begin
              state_nxt = C2C;
              resp_nxt  = hit_idx;
            end else begin
              state_nxt = LOAD;
            end
          end else if (state == C2C) begin
            ccif.ccwait[grant] = 1'b1;
            ccif.dload[grant]  = ccif.dstore[resp];
            ccif.ramWEN        = 1'b1;
            ccif.ramaddr       = ccif.daddr[resp];
            ccif.ramstore      = ccif.dstore[resp];
            if (access) begin
              ccif.dwait[grant] = 1'b0;
              ccif.dwait[resp]  = 1'b0;
              word_step         = 1'b1;
            end
          end else begin
            ccif.ramREN       = 1'b1;
            ccif.ramaddr      = ccif.daddr[grant];
            ccif.dload[grant] = ccif.ramload;
            if (access) begin
              ccif.dwait[grant] = 1'b0;
              word_step         = 1'b1;
            end
          end
        end
      end
      IFETCH: begin
        if (!ccif.iREN[grant]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          ccif.ramREN       = 1'b1;
          ccif.ramaddr      = ccif.iaddr[grant];
          ccif.iload[grant] = ccif.ramload;
          if (access) begin
            ccif.iwait[grant] = 1'b0;
            finish            = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (word_step) begin
      if (word_cnt == LAST_WORD) finish = 1'b1;
      else                       cnt_nxt = word_cnt + CNT_W'(1);
    end
    if (finish) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      grant    <= '0;
      resp     <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      resp     <= resp_nxt;
      word_cnt <= cnt_nxt;
      // Only completed transactions move the pointer; withdrawals leave it.
      if (finish) rr_ptr <= (grant == CPUID_W'(CPUS - 1)) ? '0 : grant + CPUID_W'(1);
    end
  end

`ifdef COHERENCE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c2c_cnt     <= '0;
      memload_cnt <= '0;
    end else begin
      if (finish && state == C2C && c2c_cnt != '1)
        c2c_cnt <= c2c_cnt + 32'd1;
      if (finish && state == LOAD && memload_cnt != '1)
        memload_cnt <= memload_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic      clk = 1'b0;
  logic      nrst = 1'b0;
  logic      ram_hold = 1'b0;
  ramstate_t ram_forced = BUSY;
  int        checks = 0;
  int        errors = 0;

  cache_control_if #(.CPUS(4)) ccif ();

`ifdef COHERENCE_STATS_EN
  logic [31:0] c2c_cnt, memload_cnt;
`endif

  coherence_bus_ctrl #(.CPUS(4), .BLOCK_WORDS(2)) dut (
    .CLK(clk),
    .nRST(nrst),
    .ccif(ccif.cc)
`ifdef COHERENCE_STATS_EN
    ,
    .c2c_cnt(c2c_cnt),
    .memload_cnt(memload_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: data is a fixed function of address; zero-wait unless held.
  assign ccif.ramload  = ccif.ramaddr ^ K;
  assign ccif.ramstate = ram_hold ? ram_forced
                       : ((ccif.ramREN || ccif.ramWEN) ? ACCESS : FREE);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  iren;
    logic [3:0]  iwait;
    logic        ren;
    logic [31:0] addr;
  } fvec_t;

  fvec_t vecs [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_iload;

    vecs[0]  = '{4'hF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{4'hF, 4'hE, 1'b1, 32'h1000};
    vecs[2]  = '{4'hF, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{4'hF, 4'hD, 1'b1, 32'h1010};
    vecs[4]  = '{4'hF, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{4'hF, 4'hB, 1'b1, 32'h1020};
    vecs[6]  = '{4'hF, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{4'hF, 4'h7, 1'b1, 32'h1030};
    vecs[8]  = '{4'hF, 4'hF, 1'b0, 32'h0};
    vecs[9]  = '{4'hF, 4'hE, 1'b1, 32'h1000};
    vecs[10] = '{4'h0, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{4'hA, 4'hF, 1'b0, 32'h0};
    vecs[12] = '{4'hA, 4'hD, 1'b1, 32'h1010};
    vecs[13] = '{4'hA, 4'hF, 1'b0, 32'h0};
    vecs[14] = '{4'hA, 4'h7, 1'b1, 32'h1030};
    vecs[15] = '{4'h3, 4'hF, 1'b0, 32'h0};
    vecs[16] = '{4'h3, 4'hE, 1'b1, 32'h1000};
    vecs[17] = '{4'h0, 4'hF, 1'b0, 32'h0};

    ccif.iREN = '0; ccif.dREN = '0; ccif.dWEN = '0;
    ccif.ccwrite = '0; ccif.cctrans = '0;
    ccif.daddr = '0; ccif.dstore = '0;
    for (int i = 0; i < 4; i++) ccif.iaddr[i] = 32'h1000 + 32'(i * 16);

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_ctl", {ccif.iwait, ccif.dwait, ccif.ramREN, ccif.ramWEN, ccif.ccwait, ccif.ccinv},
        {4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0});
    chk("reset_ram", {ccif.ramaddr, ccif.ramstore}, 64'h0);
    chk("reset_loads", ccif.iload | ccif.dload | ccif.ccsnoopaddr, 128'h0);
    nrst = 1'b1;

    // Instruction fetch round-robin
    for (int i = 0; i < 18; i++) begin
      ccif.iREN = vecs[i].iren;
      #1;
      exp_iload = '0;
      for (int c = 0; c < 4; c++)
        if (!vecs[i].iwait[c]) exp_iload[c*32 +: 32] = vecs[i].addr ^ K;
      chk($sformatf("fetch_v%0d", i), {ccif.iwait, ccif.ramREN, ccif.ramWEN, ccif.ramaddr},
          {vecs[i].iwait, vecs[i].ren, 1'b0, vecs[i].addr});
      chk($sformatf("fetch_iload_v%0d", i), ccif.iload, exp_iload);
      @(negedge clk);
    end

    // Snoop miss -> LOAD from RAM
    ccif.dREN = 4'b0100; ccif.daddr[2] = 32'h100;
    #1 chk("load_idle", {ccif.ramREN, ccif.ramWEN}, 2'b00);
    @(negedge clk); #1;
    chk("load_snoop_wait", {ccif.ccwait, ccif.ramREN}, {4'hF, 1'b0});
    chk("load_snoop_addr", ccif.ccsnoopaddr, {32'h100, 32'h0, 32'h100, 32'h100});
    @(negedge clk); #1;
    chk("load_w0", {ccif.ramREN, ccif.ramaddr, ccif.dwait, ccif.ccinv}, {1'b1, 32'h100, 4'hB, 4'h0});
    chk("load_d0", ccif.dload, {32'h0, 32'hA5A5_0100, 32'h0, 32'h0});
    @(negedge clk); ccif.daddr[2] = 32'h104;
    #1 chk("load_w1", {ccif.ramREN, ccif.ramaddr, ccif.dwait}, {1'b1, 32'h104, 4'hB});
    chk("load_d1", ccif.dload, {32'h0, 32'hA5A5_0104, 32'h0, 32'h0});
    @(negedge clk); ccif.dREN = '0;
    #1 chk("load_done", {ccif.ramREN, ccif.dwait}, {1'b0, 4'hF});
`ifdef COHERENCE_STATS_EN
    chk("stats_load1", memload_cnt, 32'd1);
`endif

    // Snoop hit -> cache-to-cache forward with invalidate
    @(negedge clk);
    ccif.dREN = 4'b0010; ccif.ccwrite = 4'b0010; ccif.daddr[1] = 32'h200;
    ccif.cctrans = 4'b1000; ccif.dstore[3] = 32'hDEAD_BEEF; ccif.daddr[3] = 32'h200;
    @(negedge clk); #1;
    chk("c2c_snoop", {ccif.ccwait, ccif.ramREN, ccif.ramWEN}, {4'hF, 2'b00});
    chk("c2c_snoop_addr", ccif.ccsnoopaddr, {32'h200, 32'h200, 32'h0, 32'h200});
    @(negedge clk); #1;
    chk("c2c_w0", {ccif.ramWEN, ccif.ramREN, ccif.ramaddr, ccif.ramstore, ccif.dwait},
        {1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'h5});
    chk("c2c_fwd0", ccif.dload, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0});
    chk("c2c_inv", {ccif.ccinv, ccif.ccwait}, {4'hD, 4'hF});
    @(negedge clk);
    ccif.dstore[3] = 32'hCAFE_F00D; ccif.daddr[3] = 32'h204; ccif.daddr[1] = 32'h204;
    #1 chk("c2c_w1", {ccif.ramWEN, ccif.ramaddr, ccif.ramstore, ccif.dwait},
           {1'b1, 32'h204, 32'hCAFE_F00D, 4'h5});
    chk("c2c_fwd1", ccif.dload, {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0});
    @(negedge clk); ccif.dREN = '0; ccif.cctrans = '0; ccif.ccwrite = '0;
    #1 chk("c2c_done", {ccif.ramWEN, ccif.dwait, ccif.ccinv, ccif.ccwait}, {1'b0, 4'hF, 4'h0, 4'h0});
`ifdef COHERENCE_STATS_EN
    chk("stats_c2c1", c2c_cnt, 32'd1);
`endif

    // Simultaneous dWEN (CPU0) and dREN (CPU1): writeback first, then stalled LOAD
    @(negedge clk);
    ccif.dWEN = 4'b0001; ccif.daddr[0] = 32'h300; ccif.dstore[0] = 32'h1111_1111;
    ccif.dREN = 4'b0010; ccif.daddr[1] = 32'h400;
    @(negedge clk); #1;
    chk("wb_w0", {ccif.ramWEN, ccif.ramREN, ccif.ramaddr, ccif.ramstore, ccif.dwait, ccif.ccwait},
        {1'b1, 1'b0, 32'h300, 32'h1111_1111, 4'hE, 4'h0});
    @(negedge clk); ccif.daddr[0] = 32'h304; ccif.dstore[0] = 32'h2222_2222;
    #1 chk("wb_w1", {ccif.ramWEN, ccif.ramREN, ccif.ramaddr, ccif.ramstore, ccif.dwait, ccif.ccwait},
           {1'b1, 1'b0, 32'h304, 32'h2222_2222, 4'hE, 4'h0});
    @(negedge clk); ccif.dWEN = '0;
    #1 chk("wb_idle", {ccif.ramWEN, ccif.ramREN, ccif.dwait, ccif.ccwait}, {2'b00, 4'hF, 4'h0});
    @(negedge clk); #1;
    chk("wb_then_snoop", ccif.ccsnoopaddr, {32'h400, 32'h400, 32'h0, 32'h400});
    @(negedge clk); ram_hold = 1'b1; ram_forced = BUSY;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) ram_forced = ERROR;
      #1 chk($sformatf("stall_c%0d", i), {ccif.ramREN, ccif.ramaddr, ccif.dwait}, {1'b1, 32'h400, 4'hF});
    end
    @(negedge clk); ram_hold = 1'b0;
    #1 chk("stall_w0", {ccif.ramREN, ccif.ramaddr, ccif.dwait}, {1'b1, 32'h400, 4'hD});
    @(negedge clk); ccif.daddr[1] = 32'h404;
    #1 chk("stall_w1", {ccif.ramREN, ccif.ramaddr, ccif.dwait}, {1'b1, 32'h404, 4'hD});
    @(negedge clk); ccif.dREN = '0;
    #1 chk("stall_done", {ccif.ramREN, ccif.dwait}, {1'b0, 4'hF});
`ifdef COHERENCE_STATS_EN
    chk("stats_load2", memload_cnt, 32'd2);
`endif

    // Reset asserted in the middle of a C2C block
    @(negedge clk);
    ccif.dREN = 4'b1000; ccif.daddr[3] = 32'h500; ccif.ccwrite = 4'b1000;
    ccif.cctrans = 4'b0001; ccif.dstore[0] = 32'h5555_5555; ccif.daddr[0] = 32'h500;
    repeat (2) @(negedge clk);
    #1 chk("rst_c2c_w0", {ccif.ramWEN, ccif.ramaddr, ccif.ramstore, ccif.dwait},
           {1'b1, 32'h500, 32'h5555_5555, 4'h6});
    #2 nrst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_ctl", {ccif.iwait, ccif.dwait, ccif.ramREN, ccif.ramWEN, ccif.ccwait, ccif.ccinv},
        {4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0});
    chk("rst_mid_ram", {ccif.ramaddr, ccif.ramstore}, 64'h0);
    chk("rst_mid_loads", ccif.iload | ccif.dload | ccif.ccsnoopaddr, 128'h0);
`ifdef COHERENCE_STATS_EN
    chk("rst_mid_stats", {c2c_cnt, memload_cnt}, 64'h0);
`endif
    ccif.dREN = '0; ccif.cctrans = '0; ccif.ccwrite = '0;
    @(negedge clk); nrst = 1'b1;

    // Requester withdraws during LOAD: pointer must stay at 0
    ccif.dREN = 4'b0100; ccif.daddr[2] = 32'h600;
    repeat (2) @(negedge clk);
    ram_hold = 1'b1; ram_forced = BUSY;
    #1 chk("wd_load", {ccif.ramREN, ccif.ramaddr, ccif.dwait}, {1'b1, 32'h600, 4'hF});
    @(negedge clk); ccif.dREN = '0;
    #1 chk("wd_drop", {ccif.ramREN, ccif.dwait}, {1'b0, 4'hF});
    @(negedge clk); ram_hold = 1'b0; ccif.iREN = 4'b1001;
    #1 chk("wd_idle", {ccif.ramREN, ccif.iwait}, {1'b0, 4'hF});
    @(negedge clk);
    #1 chk("wd_rr_hold", {ccif.ramREN, ccif.ramaddr, ccif.iwait}, {1'b1, 32'h1000, 4'hE});
    @(negedge clk); ccif.iREN = '0;
    #1 chk("wd_end", {ccif.ramREN, ccif.iwait}, {1'b0, 4'hF});
`ifdef COHERENCE_STATS_EN
    chk("wd_stats", memload_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
